// File: rtl/uart_mmio_responder_if.sv
// CPU-side memory bus seen by the UART responder: native read strobe / byte write mask.
interface uart_mmio_responder_if;
    logic        sel;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    modport master (output sel, mem_addr, mem_rstrb, mem_wdata, mem_wmask, input mem_rdata);
    modport slave  (input sel, mem_addr, mem_rstrb, mem_wdata, mem_wmask, output mem_rdata);
endinterface

// File: rtl/uart_mmio_responder.sv
// IO-page UART responder: TX/RX byte FIFOs behind TX_DATA / RX_DATA / STATUS words,
// with a small FSM draining the TX FIFO into the uart_tx serializer.
module uart_mmio_responder #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_responder_if.slave  bus,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    input  logic                  tx_active,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state;
    logic [1:0]            tmr;
    logic [7:0]            rx_mem [DEPTH];
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [DEPTH_LOG2:0]   rx_cnt, tx_cnt;
    logic                  rx_overrun, tx_drop;
    logic                  rd, wr, off_tx, off_rx, off_st, st_rd;
    logic                  rx_pop, rx_push, rx_ovf, tx_pop, tx_push, tx_ovf;
    logic [31:0]           status;
    logic                  unused_bits;

    assign unused_bits = ^{bus.mem_addr[31:6], bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    assign rd     = bus.sel & bus.mem_rstrb;
    assign wr     = bus.sel & (|bus.mem_wmask);
    assign off_tx = bus.mem_addr[5:2] == 4'b0010;
    assign off_rx = bus.mem_addr[5:2] == 4'b0100;
    assign off_st = bus.mem_addr[5:2] == 4'b1000;
    assign st_rd  = rd & off_st;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign rx_pop  = rd & off_rx & (rx_cnt != '0);
    assign rx_push = rx_dv & ((rx_cnt != FULL) | rx_pop);
    assign rx_ovf  = rx_dv & ~rx_push;
    assign tx_pop  = (state == IDLE) & ~tx_active & (tx_cnt != '0);
    assign tx_push = wr & off_tx & ((tx_cnt != FULL) | tx_pop);
    assign tx_ovf  = wr & off_tx & ~tx_push;

    always_comb begin
        status        = '0;
        status[0]     = tx_cnt != FULL;
        status[1]     = rx_cnt != '0;
        status[2]     = rx_overrun;
        status[3]     = tx_drop;
        status[4]     = (state == IDLE) & (tx_cnt == '0);
        status[15:8]  = 8'(rx_cnt);
        status[23:16] = 8'(tx_cnt);
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_byte;
        if (tx_push) tx_mem[tx_wp] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp      <= '0;
            rx_rp      <= '0;
            rx_cnt     <= '0;
            tx_wp      <= '0;
            tx_rp      <= '0;
            tx_cnt     <= '0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (rx_pop & ~rx_push) rx_cnt <= rx_cnt - 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (tx_pop & ~tx_push) tx_cnt <= tx_cnt - 1'b1;
            // A flag event coinciding with the clearing STATUS read keeps the flag set.
            rx_overrun <= rx_ovf | (rx_overrun & ~st_rd);
            tx_drop    <= tx_ovf | (tx_drop & ~st_rd);
            if (rd) begin
                if (rx_pop)      bus.mem_rdata <= {24'b0, rx_mem[rx_rp]};
                else if (off_st) bus.mem_rdata <= status;
                else             bus.mem_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmr     <= '0;
            tx_dv   <= 1'b0;
            tx_byte <= '0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                IDLE: if (tx_pop) begin
                    tx_byte <= tx_mem[tx_rp];
                    tx_dv   <= 1'b1;
                    state   <= START;
                end
                START: begin
                    tmr   <= '0;
                    state <= WAIT_BUSY;
                end
                // Bounded wait so a busy flag that never rises cannot stall the engine.
                WAIT_BUSY: begin
                    if (tx_active)         state <= WAIT_DONE;
                    else if (tmr == 2'd3)  state <= IDLE;
                    else                   tmr   <= tmr + 1'b1;
                end
                WAIT_DONE: if (!tx_active) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_responder.sv
// Bench for uart_mmio_responder: vector tables, directed TX/reset sequences and a
// randomized run against a queue-based model of the register map.
module tb_uart_mmio_responder;
    localparam int DEPTH = 8;
    localparam logic [3:0] O_TX = 4'b0010, O_RX = 4'b0100, O_ST = 4'b1000, O_NO = 4'b0001;

    typedef struct {
        bit          sel, rd, wr;
        logic [3:0]  off;
        logic [7:0]  wdat;
        bit          rxv;
        logic [7:0]  rxb;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, tx_dv, tx_active, rx_dv = 1'b0;
    logic [7:0] tx_byte, rx_byte = '0;
    uart_mmio_responder_if bus();

    uart_mmio_responder #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .bus(bus), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .tx_active(tx_active), .rx_dv(rx_dv), .rx_byte(rx_byte)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nerr = 0, cyc = 0, busy_left = 0;
    bit force_busy = 1'b0;
    logic [7:0] tx_log[$];
    int tx_time[$];
    logic [7:0] rxq[$], txq[$];
    bit m_ovr, m_drp;
    vec_t vq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer stand-in: busy for 20 cycles starting the cycle after each tx_dv.
    initial begin
        tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (force_busy) tx_active = 1'b1;
            else if (busy_left > 0) begin tx_active = 1'b1; busy_left--; end
            else tx_active = 1'b0;
            if (tx_dv) begin
                tx_log.push_back(tx_byte);
                tx_time.push_back(cyc);
                busy_left = 20;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit s, bit r, bit w, logic [3:0] off, logic [7:0] wd,
                                bit rv, logic [7:0] rb, bit c, logic [31:0] e);
        vec_t v;
        v.sel = s; v.rd = r; v.wr = w; v.off = off; v.wdat = wd;
        v.rxv = rv; v.rxb = rb; v.chk = c; v.exp = e;
        return v;
    endfunction
    function automatic vec_t rdv(logic [3:0] off, logic [31:0] e); return mk(1, 1, 0, off, 8'h0, 0, 8'h0, 1, e); endfunction
    function automatic vec_t wrv(logic [3:0] off, logic [7:0] d); return mk(1, 0, 1, off, d, 0, 8'h0, 0, 0); endfunction
    function automatic vec_t rxv(logic [7:0] b); return mk(0, 0, 0, 4'h0, 8'h0, 1, b, 0, 0); endfunction

    task automatic idle();
        bus.sel = 1'b0; bus.mem_rstrb = 1'b0; bus.mem_wmask = 4'h0;
        bus.mem_addr = '0; bus.mem_wdata = '0; rx_dv = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        logic [31:0] a;
        a = $urandom();
        a[5:2] = v.off;
        bus.sel = v.sel; bus.mem_addr = a; bus.mem_rstrb = v.rd;
        bus.mem_wmask = v.wr ? 4'($urandom_range(1, 15)) : 4'h0;
        bus.mem_wdata = {24'($urandom()), v.wdat};
        rx_dv = v.rxv; rx_byte = v.rxv ? v.rxb : 8'($urandom());
        @(negedge clk);
        idle();
        if (v.chk) check($sformatf("%s[%0d]", tag, idx), bus.mem_rdata, v.exp);
    endtask

    task automatic run_vq(input string tag);
        for (int i = 0; i < vq.size(); i++) apply(vq[i], tag, i);
        vq.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int bound, input string name);
        int k = 0;
        while (tx_log.size() < n && k < bound) begin @(negedge clk); k++; end
        check(name, 32'(tx_log.size()), 32'(n));
    endtask

    // Reset cycle carries a TX write, RX read and rx_dv that must all be ignored.
    task automatic do_reset();
        reset = 1'b1; bus.sel = 1'b1; bus.mem_rstrb = 1'b1; bus.mem_wmask = 4'hF;
        bus.mem_addr = 32'h0000_0008; bus.mem_wdata = 32'hEE; rx_dv = 1'b1; rx_byte = 8'hEE;
        @(negedge clk);
        reset = 1'b0;
        idle();
        rxq.delete(); txq.delete(); m_ovr = 1'b0; m_drp = 1'b0;
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0] = txq.size() < DEPTH;
        s[1] = rxq.size() > 0;
        s[2] = m_ovr;
        s[3] = m_drp;
        s[4] = txq.size() == 0;
        s[15:8] = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
        return s;
    endfunction

    // Register-map model (valid while the TX engine is held off by a busy serializer).
    task automatic model(inout vec_t v);
        bit pop = 1'b0;
        v.chk = 1'b0;
        if (v.sel && v.rd) begin
            v.chk = 1'b1;
            if (v.off == O_RX) begin
                v.exp = (rxq.size() > 0) ? {24'b0, rxq[0]} : 32'h0;
                pop = rxq.size() > 0;
            end else if (v.off == O_ST) v.exp = m_status();
            else v.exp = 32'h0;
        end
        if (pop) void'(rxq.pop_front());
        if (v.sel && v.rd && v.off == O_ST) begin m_ovr = 1'b0; m_drp = 1'b0; end
        if (v.rxv) begin
            if (rxq.size() < DEPTH) rxq.push_back(v.rxb); else m_ovr = 1'b1;
        end
        if (v.sel && v.wr && v.off == O_TX) begin
            if (txq.size() < DEPTH) txq.push_back(v.wdat); else m_drp = 1'b1;
        end
    endtask

    initial begin
        int c0;
        idle();
        force_busy = 1'b1;
        do_reset();
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_rdata", bus.mem_rdata, 0);

        // Register map table: RX fill/drain, TX overfill with drop flag, decode corners.
        vq.push_back(rdv(O_ST, 32'h11));
        for (int i = 0; i < 8; i++) vq.push_back(rxv(8'(8'h10 + i)));
        vq.push_back(rdv(O_ST, 32'h0813));
        vq.push_back(mk(1, 0, 0, O_RX, 8'h0, 0, 8'h0, 1, 32'h0813));
        vq.push_back(mk(0, 1, 0, O_RX, 8'h0, 0, 8'h0, 1, 32'h0813));
        for (int i = 0; i < 8; i++) vq.push_back(rdv(O_RX, 32'(8'h10 + i)));
        vq.push_back(rdv(O_RX, 32'h0));
        vq.push_back(rdv(O_ST, 32'h11));
        for (int i = 0; i < 9; i++) vq.push_back(wrv(O_TX, 8'(8'hA0 + i)));
        vq.push_back(rdv(O_ST, 32'h0008_0008));
        vq.push_back(rdv(O_ST, 32'h0008_0000));
        vq.push_back(mk(0, 0, 1, O_TX, 8'h55, 0, 8'h0, 0, 0));
        vq.push_back(wrv(O_ST, 8'hFF));
        vq.push_back(rdv(O_ST, 32'h0008_0000));
        vq.push_back(rdv(O_NO, 32'h0));
        vq.push_back(rdv(O_ST, 32'h0008_0000));
        run_vq("table");

        tx_log.delete(); tx_time.delete();
        force_busy = 1'b0;
        wait_log(8, 400, "table_drain_n");
        for (int i = 0; i < tx_log.size() && i < 8; i++)
            check($sformatf("table_drain[%0d]", i), 32'(tx_log[i]), 32'(8'hA0 + i));
        cycles(30);

        // RX push+pop on a full FIFO, then overrun on a push with no pop.
        do_reset();
        for (int i = 0; i < 8; i++) vq.push_back(rxv(8'(8'h20 + i)));
        vq.push_back(mk(1, 1, 0, O_RX, 8'h0, 1, 8'h99, 1, 32'h20));
        vq.push_back(rdv(O_ST, 32'h0813));
        for (int i = 1; i < 8; i++) vq.push_back(rdv(O_RX, 32'(8'h20 + i)));
        vq.push_back(rdv(O_RX, 32'h99));
        vq.push_back(rdv(O_RX, 32'h0));
        for (int i = 0; i < 9; i++) vq.push_back(rxv(8'(8'h30 + i)));
        vq.push_back(rdv(O_ST, 32'h0817));
        vq.push_back(rdv(O_ST, 32'h0813));
        vq.push_back(rdv(O_RX, 32'h30));
        run_vq("rxfull");

        // TX latency and spacing with a 20-cycle serializer.
        do_reset();
        tx_log.delete(); tx_time.delete();
        cycles(2);
        c0 = cyc;
        vq.push_back(wrv(O_TX, 8'h41));
        vq.push_back(wrv(O_TX, 8'h42));
        vq.push_back(wrv(O_TX, 8'h43));
        run_vq("txw");
        wait_log(3, 200, "tx3_n");
        if (tx_log.size() == 3) begin
            check("tx3_b0", 32'(tx_log[0]), 32'h41);
            check("tx3_b1", 32'(tx_log[1]), 32'h42);
            check("tx3_b2", 32'(tx_log[2]), 32'h43);
            check("tx3_latency", 32'(tx_time[0] - c0), 32'd2);
            check("tx3_gap01_ge22", 32'(tx_time[1] - tx_time[0] >= 22), 1);
            check("tx3_gap12_ge22", 32'(tx_time[2] - tx_time[1] >= 22), 1);
        end
        cycles(30);
        vq.push_back(rdv(O_ST, 32'h11));
        run_vq("tx3_idle");

        // Reset while the engine waits on the serializer with both FIFOs loaded.
        do_reset();
        tx_log.delete(); tx_time.delete();
        for (int i = 0; i < 6; i++) begin
            vec_t v = wrv(O_TX, 8'(8'h60 + i));
            if (i < 3) begin v.rxv = 1'b1; v.rxb = 8'(8'h70 + i); end
            vq.push_back(v);
        end
        run_vq("midw");
        wait_log(1, 50, "mid_first");
        cycles(4);
        do_reset();
        vq.push_back(rdv(O_ST, 32'h11));
        run_vq("mid_rst");
        check("mid_tx_byte", 32'(tx_byte), 0);
        cycles(100);
        check("mid_no_more_tx", 32'(tx_log.size()), 1);
        vq.push_back(rdv(O_ST, 32'h11));
        vq.push_back(rdv(O_RX, 32'h0));
        run_vq("mid_end");

        // Randomized traffic against the model with the TX engine held off.
        force_busy = 1'b1;
        cycles(2);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            vec_t v;
            int op = $urandom_range(0, 5);
            int p = ((i / 100) % 2 == 1) ? 25 : 70;
            v = mk(0, 0, 0, 4'h0, 8'($urandom()), $urandom_range(0, 99) < p, 8'($urandom()), 0, 0);
            case (op)
                1: begin v.sel = 1; v.rd = 1; v.off = O_RX; end
                2: begin v.sel = 1; v.rd = 1; v.off = O_ST; end
                3: begin v.sel = 1; v.wr = 1; v.off = O_TX; end
                4: begin v.sel = 1; v.rd = 1; v.off = ($urandom_range(0, 1) == 1) ? O_NO : O_TX; end
                5: begin v.sel = 1; v.wr = 1; v.off = ($urandom_range(0, 1) == 1) ? O_RX : O_ST; end
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) v.sel = 0;
            model(v);
            apply(v, "rand", i);
        end
        tx_log.delete(); tx_time.delete();
        force_busy = 1'b0;
        wait_log(txq.size(), 400, "rand_drain_n");
        for (int i = 0; i < tx_log.size() && i < txq.size(); i++)
            check($sformatf("rand_drain[%0d]", i), 32'(tx_log[i]), 32'(txq[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/uart_mmio_responder.md
# uart_mmio_responder

Memory-mapped UART responder for the processor's IO page. It answers the CPU's native memory-bus strobes (`mem_rstrb` / `mem_wmask`) and buffers bytes in both directions through TX and RX FIFOs. It drains the TX FIFO into the existing `uart_tx` serializer and fills the RX FIFO from the `uart_rx` byte strobe. It replaces the ad-hoc UART decode in `soc` and removes software busy-waiting on every byte.

## Interface

- `DEPTH_LOG2`, 3, log2 of each FIFO depth (default 8 entries per direction).
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `sel` input 1: IO-page select from `soc` (`mem_addr[22]`); gates every bus access.
- `mem_addr` input 32: byte address; only `[5:2]` are decoded, as a one-hot word offset.
- `mem_rstrb` input 1: one-cycle read strobe from the CPU.
- `mem_wdata` input 32: write data; only `[7:0]` are used.
- `mem_wmask` input 4: byte write mask; a write occurs when any bit is set.
- `mem_rdata` output 32: registered read data.
- `tx_dv` output 1: one-cycle start pulse to `uart_tx`.
- `tx_byte` output 8: byte for `uart_tx`; held stable from `tx_dv` until the transfer completes.
- `tx_active` input 1: `uart_tx` busy flag.
- `rx_dv` input 1: one-cycle byte-valid pulse from `uart_rx`.
- `rx_byte` input 8: received byte; valid when `rx_dv` is high.

## Operation

Register map. An access is decoded only when `sel` is high. Exactly one offset bit is expected to be set.
- `mem_addr[3]` set: TX_DATA, write-only.
  - Write pushes `mem_wdata[7:0]` into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and sticky `tx_drop` is set.
- `mem_addr[4]` set: RX_DATA, read-only.
  - Read returns `{24'b0, head}` and pops one entry.
  - If the RX FIFO is empty, the read returns 0 and nothing is popped.
- `mem_addr[5]` set: STATUS, read-only. Bit layout:
  - bit0 = TX FIFO not full.
  - bit1 = RX FIFO not empty.
  - bit2 = `rx_overrun`.
  - bit3 = `tx_drop`.
  - bit4 = TX engine idle and TX FIFO empty.
  - `[15:8]` = RX count.
  - `[23:16]` = TX count.
  - All other bits are 0.
  - A STATUS read clears `rx_overrun` and `tx_drop` after their values are captured.
  - A flag event in the same cycle as the clearing read leaves the flag set.
- Any other offset: reads return 0, writes are ignored.
- Writes to RX_DATA or STATUS and reads of TX_DATA have no side effects.

FIFOs:
- Two independent circular buffers, each `2**DEPTH_LOG2` entries × 8 bits.
- Pointers are `DEPTH_LOG2` bits and wrap modulo depth.
- Counts are `DEPTH_LOG2+1` bits, range 0..depth, zero-extended into the STATUS fields.

RX push:
- `rx_dv` pushes `rx_byte`.
- If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and `rx_overrun` is set.
- Simultaneous push and pop is always accepted:
  - the count is unchanged;
  - the popped value is the pre-push head;
  - when full, no overrun is flagged.
- TX push and drain pop in the same cycle follow the same rule.

TX drain FSM (`IDLE`, `START`, `WAIT_BUSY`, `WAIT_DONE`):
- `IDLE`: if the TX FIFO is non-empty and `tx_active` is 0, pop the head into `tx_byte` and go to `START`.
- `START`: drive `tx_dv` high for exactly this cycle, then go to `WAIT_BUSY`.
- `WAIT_BUSY`: go to `WAIT_DONE` when `tx_active` is 1. A 4-cycle timeout returns to `IDLE` so a missed busy flag cannot hang the engine.
- `WAIT_DONE`: go to `IDLE` when `tx_active` is 0.

## Timing

Reset values:
- `mem_rdata` = 0, `tx_dv` = 0, `tx_byte` = 0.
- Both FIFOs empty, both sticky flags cleared, FSM in `IDLE`.
- Reset wins over any same-cycle bus or UART event.
- Reset mid-transfer discards all FIFO contents and returns the FSM to `IDLE` immediately. The serializer may finish its current frame.

Read path:
- `mem_rdata` is captured on the clock edge that samples `sel & mem_rstrb`. It is valid the next cycle and holds until the next selected read.
- This matches the CPU's `WAIT_INSTR` / `WAIT_DATA` sampling.
- The RX pop and the STATUS flag-clear commit on that same edge. Holding the address without `mem_rstrb` pops nothing.

Write path:
- A write takes effect on the edge where `sel & |mem_wmask` is high.
- The CPU holds a store for one cycle, so each store pushes exactly one byte.

TX latency:
- Byte pushed at edge N: `tx_dv` is high during cycle N+2, provided the FSM was idle and `tx_active` was 0.
- Back-to-back bytes are separated by the full frame time plus 3 cycles.

RX latency:
- `rx_dv` at edge N makes the byte visible in STATUS bit1 and RX count from cycle N+1.

## Test plan

- Reset, then read STATUS → `mem_rdata` = 0x00000011.
- Write 0x41, 0x42, 0x43 to TX_DATA with a `tx_active` model of 20 cycles busy starting one cycle after `tx_dv` → three `tx_dv` pulses with `tx_byte` 0x41, 0x42, 0x43 in order. Pulses are ≥22 cycles apart. STATUS bit4 returns to 1 afterwards.
- Hold `tx_active` high and write 9 bytes (DEPTH_LOG2=3) → STATUS = TX count 8, bit0 = 0, bit3 = 1. A second STATUS read shows bit3 = 0.
- Pulse `rx_dv` with 0x10..0x17, then read RX_DATA 9 times → 0x10..0x17, then 0. RX count reaches 0.
- Fill the RX FIFO to 8, then in one cycle assert `rx_dv` (0x99) together with a RX_DATA read → the read returns the old head, count stays 8, `rx_overrun` = 0, 0x99 is the last entry. A further `rx_dv` with no read sets `rx_overrun`.
- Assert `reset` for one cycle while in `WAIT_DONE` with 5 TX and 3 RX bytes buffered → next cycle STATUS = 0x00000011 and no further `tx_dv` pulses occur.
